// File: rtl/gcd_sched_pkg.sv
// Shared types and constants for the GCD job scheduler and its completion FIFO.
package gcd_sched_pkg;

    localparam int OPCODE_W  = 3;
    localparam int CYCLE_W   = 12;
    localparam int REC_IDX_W = 2;
    localparam int REC_ID_W  = 8;

    localparam logic [CYCLE_W-1:0] TIMEOUT_CYCLES = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RECOVER = 2'd3
    } sched_state_e;

    // Fields are sized for the widest supported configuration; the top narrows them.
    typedef struct packed {
        logic [REC_IDX_W-1:0] req_idx;
        logic [REC_ID_W-1:0]  id;
        logic [CYCLE_W-1:0]   cycles;
        logic                 timeout;
    } cpl_rec_t;

endpackage

// File: rtl/gcd_cpl_fifo.sv
// Completion-record FIFO: push/pop qualified by CLKEN, head entry presented on rdata.
module gcd_cpl_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic                   CLKEN,
    input  logic                   push,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   pop,
    output logic [DATA_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Qualify requests so a misbehaving caller cannot overrun or underrun the storage.
    always_comb begin
        push_ok_s = CLKEN & push & (count_r != FULL_CNT);
        pop_ok_s  = CLKEN & pop & (count_r != '0);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/gcd_job_scheduler.sv
// Round-robin job scheduler for the shared GCD core: launches one job at a time,
// detects completion or watchdog expiry and queues completion records that raise IRQ.
module gcd_job_scheduler
    import gcd_sched_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ID_W      = 4,
    parameter int TIMEOUT_W = 16,
    parameter int CQ_DEPTH  = 4
) (
    input  logic                         CLK,
    input  logic                         RESETn,
    input  logic                         CLKEN,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [3*NUM_REQ-1:0]         req_opcode,
    input  logic [NUM_REQ-1:0]           req_ct,
    input  logic [ID_W*NUM_REQ-1:0]      req_id,
    input  logic [TIMEOUT_W-1:0]         timeout_limit,
    input  logic                         irq_en,
    output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
    output logic                         gcd_start,
    output logic [2:0]                   gcd_opcode,
    output logic                         gcd_constant_time,
    input  logic                         gcd_done,
    input  logic [11:0]                  gcd_cycle_count,
    output logic                         cpl_valid,
    input  logic                         cpl_ready,
    output logic [$clog2(NUM_REQ)-1:0]   cpl_req_idx,
    output logic [ID_W-1:0]              cpl_id,
    output logic [11:0]                  cpl_cycles,
    output logic                         cpl_timeout,
    output logic                         busy,
    output logic                         irq
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(CQ_DEPTH) + 1;

    sched_state_e          state_r;
    logic [IDX_W-1:0]      rr_ptr_r;
    logic [IDX_W-1:0]      grant_r;
    logic [OPCODE_W-1:0]   op_r;
    logic                  ct_r;
    logic [ID_W-1:0]       id_r;
    logic                  done_prev_r;
    logic [TIMEOUT_W-1:0]  wdog_r;
    logic                  irq_r;

    logic [IDX_W-1:0]      winner_s;
    logic                  done_rise_s;
    logic                  timeout_hit_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;
    logic [CNT_W-1:0]      cq_count_s;
    cpl_rec_t              push_rec_s;
    cpl_rec_t              head_rec_s;
    logic [$bits(cpl_rec_t)-1:0] head_bits_s;

    // Nearest valid requester after the pointer wins; iterating from the far end lets it override.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = ptr;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx  = (int'(ptr) + i) % NUM_REQ;
            pick = valid[idx] ? IDX_W'(idx) : pick;
        end
        return pick;
    endfunction

    // Arbitration, completion detection and record assembly.
    always_comb begin
        winner_s      = rr_pick(req_valid, rr_ptr_r);
        done_rise_s   = gcd_done & ~done_prev_r;
        timeout_hit_s = (timeout_limit != '0) && (wdog_r == (timeout_limit - TIMEOUT_W'(1)));
        accept_s      = CLKEN & (state_r == ST_IDLE) & (|req_valid)
                      & (cq_count_s < CNT_W'(CQ_DEPTH));
        push_s        = CLKEN & (state_r == ST_WAIT) & (done_rise_s | timeout_hit_s);
        pop_s         = cpl_valid & cpl_ready;
        req_ready     = '0;
        if (accept_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
        push_rec_s.req_idx = REC_IDX_W'(grant_r);
        push_rec_s.id      = REC_ID_W'(id_r);
        push_rec_s.cycles  = done_rise_s ? gcd_cycle_count : TIMEOUT_CYCLES;
        push_rec_s.timeout = ~done_rise_s;
        head_rec_s         = cpl_rec_t'(head_bits_s);
    end

    // Job sequencing FSM with its held job attributes, watchdog and IRQ register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= IDX_W'(NUM_REQ - 1);
            grant_r     <= '0;
            op_r        <= '0;
            ct_r        <= 1'b0;
            id_r        <= '0;
            done_prev_r <= 1'b0;
            wdog_r      <= '0;
            irq_r       <= 1'b0;
        end else if (CLKEN) begin
            done_prev_r <= gcd_done;
            irq_r       <= irq_en & cpl_valid;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        rr_ptr_r <= winner_s;
                        grant_r  <= winner_s;
                        op_r     <= req_opcode[OPCODE_W*winner_s +: OPCODE_W];
                        ct_r     <= req_ct[winner_s];
                        id_r     <= req_id[ID_W*winner_s +: ID_W];
                        state_r  <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wdog_r  <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_rise_s) begin
                        state_r <= ST_IDLE;
                    end else if (timeout_hit_s) begin
                        state_r <= ST_RECOVER;
                    end else begin
                        wdog_r <= wdog_r + TIMEOUT_W'(1);
                    end
                end
                // The aborted job's late done must not be mistaken for the next job's.
                ST_RECOVER: begin
                    if (done_rise_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    gcd_cpl_fifo #(
        .DEPTH  (CQ_DEPTH),
        .DATA_W ($bits(cpl_rec_t))
    ) u_cpl_fifo (
        .CLK    (CLK),
        .RESETn (RESETn),
        .CLKEN  (CLKEN),
        .push   (push_s),
        .wdata  (push_rec_s),
        .pop    (pop_s),
        .rdata  (head_bits_s),
        .count  (cq_count_s)
    );

    assign gcd_start         = CLKEN & (state_r == ST_LAUNCH);
    assign busy              = (state_r != ST_IDLE);
    assign grant_idx         = grant_r;
    assign gcd_opcode        = op_r;
    assign gcd_constant_time = ct_r;
    assign irq               = irq_r;
    assign cpl_valid         = (cq_count_s != '0);
    assign cpl_req_idx       = IDX_W'(head_rec_s.req_idx);
    assign cpl_id            = ID_W'(head_rec_s.id);
    assign cpl_cycles        = head_rec_s.cycles;
    assign cpl_timeout       = head_rec_s.timeout;

endmodule

// File: doc/gcd_job_scheduler.md
Name: gcd_job_scheduler

Overview:
- Sequences the shared GCD datapath (one job in flight) on behalf of NUM_REQ requesters, e.g. the APB register file and a DMA/host-side job port.
- Round-robin arbitrates job requests, drives a one-cycle start and a held opcode/mode, and holds the operand-mux select for the whole job.
- Detects completion from the level `done`, applies a watchdog timeout, and pushes completion records into a small FIFO that raises IRQ.
- Sits between the register/AXI front end and the GCD core inside the wrapper.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- ID_W, 4: job tag width.
- TIMEOUT_W, 16: watchdog counter width.
- CQ_DEPTH, 4: completion FIFO depth (power of 2).

Ports:
- CLK  in  1  clock.
- RESETn  in  1  asynchronous active-low reset.
- CLKEN  in  1  clock enable; all state advances only when CLKEN=1.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot accept.
- req_opcode  in  3*NUM_REQ  per-requester opcode.
- req_ct  in  NUM_REQ  per-requester constant-time mode.
- req_id  in  ID_W*NUM_REQ  per-requester job tag.
- timeout_limit  in  TIMEOUT_W  watchdog limit in enabled cycles; 0 disables the watchdog.
- irq_en  in  1  interrupt enable.
- grant_idx  out  $clog2(NUM_REQ)  operand-mux select, held from accept until completion.
- gcd_start  out  1  one-cycle start pulse.
- gcd_opcode  out  3  opcode for the current job (registered).
- gcd_constant_time  out  1  constant-time mode for the current job (registered).
- gcd_done  in  1  core done level.
- gcd_cycle_count  in  12  core cycle count.
- cpl_valid  out  1  completion record available.
- cpl_ready  in  1  completion record consumed.
- cpl_req_idx  out  $clog2(NUM_REQ)  requester of the completed job.
- cpl_id  out  ID_W  tag of the completed job.
- cpl_cycles  out  12  cycle count of the completed job.
- cpl_timeout  out  1  1 = job aborted by the watchdog.
- busy  out  1  1 = state is not IDLE.
- irq  out  1  level interrupt.

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer = NUM_REQ-1 (requester 0 has first priority); FIFO empty; done_prev=0.
- CLKEN=0: no register changes. req_ready is forced 0 and gcd_start is forced 0.
- States: IDLE, LAUNCH, WAIT, RECOVER.
- IDLE:
  - If any req_valid and FIFO count < CQ_DEPTH, pick the winner round-robin, searching from pointer+1 upward with wrap.
  - Assert req_ready[winner] combinationally that cycle.
  - Register opcode, ct, id and grant_idx; set pointer = winner; go to LAUNCH.
  - If the FIFO is full, no grant is given.
- LAUNCH: gcd_start=1 for exactly one enabled cycle; clear the watchdog counter; go to WAIT.
- Done edge: done_rise = gcd_done & ~done_prev; done_prev is updated every enabled cycle.
- WAIT:
  - On done_rise: push {grant_idx, id, gcd_cycle_count, 0}; go to IDLE.
  - Else, if timeout_limit != 0 and counter == timeout_limit-1: push {grant_idx, id, 12'hFFF, 1}; go to RECOVER.
  - Otherwise increment the counter.
  - done_rise and the timeout in the same cycle: done wins.
- RECOVER: discard the next done_rise (late completion), then go to IDLE. No grants are given in RECOVER.
- done_rise in IDLE/LAUNCH is ignored (spurious).
- Ordering: the next grant occurs at the earliest in the cycle after return to IDLE. Minimum job turnaround = accept, LAUNCH, ≥1 WAIT cycle, IDLE.
- FIFO:
  - Push and pop in the same cycle are legal.
  - Push never hits a full FIFO, because space is checked at accept and count cannot rise while a job is in flight.
  - cpl_* shows the head entry; pop on cpl_valid & cpl_ready.
- irq = irq_en & cpl_valid, registered (1-cycle delay).
- busy is combinational from state.
- gcd_opcode, gcd_constant_time and grant_idx stay stable from LAUNCH through WAIT/RECOVER.
- Reset mid-job: immediately returns to reset state; the FIFO contents are lost. A late gcd_done from the core is ignored because the state is IDLE.

Decomposition:
- Package gcd_sched_pkg: state enum, OPCODE_W=3, CYCLE_W=12, completion record struct {req_idx, id, cycles, timeout}.
- Sub-module gcd_cpl_fifo: synchronous FIFO with CLKEN, async active-low reset, count output.
- The round-robin arbiter stays inline as a function.

Test Plan:
1. req_valid=2'b01, id=5, op=3 -> req_ready=01 for one cycle; gcd_start pulse next cycle with gcd_opcode=3. Then gcd_done rises with cycle_count=100 -> cpl {0,5,100,0}, irq=1 next cycle.
2. req_valid=2'b11 held for three jobs from reset -> grants go 0,1,0; grant_idx is stable during each job.
3. timeout_limit=10, no done -> cpl {idx,id,FFF,1} exactly 10 WAIT cycles after LAUNCH. A done after that is discarded and does not create a record; the scheduler then returns to IDLE.
4. cpl_ready=0 with 4 jobs completed -> FIFO full; a 5th req_valid gets no req_ready. One pop -> the grant resumes the next cycle.
5. CLKEN toggling 1/0 during WAIT -> the watchdog counts only enabled cycles; gcd_start is never longer than one enabled cycle.
6. RESETn asserted in WAIT -> busy=0, cpl_valid=0, irq=0 immediately; the pending gcd_done after release produces no record.
